// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains an 8-bit fifo_mem through its pop interface and
// emits framed bursts (sop/eop) on a valid/ready stream.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   fifo_empty       FIFO empty flag
//   fifo_threshold   FIFO threshold flag
//   fifo_data        FIFO head word, valid while fifo_empty=0
//   fifo_rd          pop strobe (combinational), head consumed at the edge
//   m_valid/m_ready  output stream handshake
//   m_data           output byte
//   m_sop/m_eop      first/last byte of a burst
//   stat_bytes       accepted-byte count (0 unless STATS_EN)
//   stat_bursts      accepted-burst count (0 unless STATS_EN)
//
// Optional feature: define STATS_EN to build the transfer/burst counters.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_threshold,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic [15:0]           stat_bytes,
  output logic [15:0]           stat_bursts
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_CLOSE} state_t;

  state_t                state_q, state_d;
  entry_t                buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                  pend_sop_q, pend_sop_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic [TMR_W-1:0]      timer_q, timer_d;

  logic   xfer;
  logic   push_ok;
  logic   push;
  entry_t push_ent;
  logic   fifo_rd_c;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0_q.data;
  assign m_sop   = buf0_q.sop;
  assign m_eop   = buf0_q.eop;
  assign xfer    = m_valid && m_ready;
  // A full buffer can still take a byte when the head leaves in the same cycle.
  assign push_ok = (occ_q != 2'd2) || xfer;
  assign fifo_rd = fifo_rd_c;

  // Burst control: decides pops and what gets pushed into the skid buffer.
  always_comb begin
    state_d     = state_q;
    pend_data_d = pend_data_q;
    pend_sop_d  = pend_sop_q;
    pend_vld_d  = pend_vld_q;
    burst_cnt_d = burst_cnt_q;
    timer_d     = timer_q;
    push        = 1'b0;
    push_ent    = '0;
    fifo_rd_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = fifo_empty ? '0 : timer_q + TMR_W'(1);
        if (fifo_threshold || (!fifo_empty && (timer_q == TMR_W'(TIMEOUT - 1)))) begin
          state_d = S_BURST;
          timer_d = '0;
        end
      end
      S_BURST: begin
        if (!fifo_empty && (!pend_vld_q || push_ok)) begin
          fifo_rd_c = 1'b1;
          if (pend_vld_q) begin
            push     = 1'b1;
            push_ent = '{data: pend_data_q, sop: pend_sop_q, eop: 1'b0};
          end
          pend_data_d = fifo_data;
          pend_sop_d  = (burst_cnt_q == '0);
          pend_vld_d  = 1'b1;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_q == CNT_W'(BURST_LEN - 1)) state_d = S_CLOSE;
        end else if (fifo_empty) begin
          // Nothing pending means nothing to close; fall back and re-arm.
          state_d = pend_vld_q ? S_CLOSE : S_IDLE;
        end
      end
      S_CLOSE: begin
        if (push_ok) begin
          push        = 1'b1;
          push_ent    = '{data: pend_data_q, sop: pend_sop_q, eop: 1'b1};
          pend_vld_d  = 1'b0;
          burst_cnt_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-entry output skid buffer, head in buf0.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({push, xfer})
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = push_ent;
        else               buf1_d = push_ent;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = push_ent;
        end else begin
          buf0_d = buf1_q;
          buf1_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf0_q      <= '0;
      buf1_q      <= '0;
      occ_q       <= 2'd0;
      pend_data_q <= '0;
      pend_sop_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      burst_cnt_q <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      occ_q       <= occ_d;
      pend_data_q <= pend_data_d;
      pend_sop_q  <= pend_sop_d;
      pend_vld_q  <= pend_vld_d;
      burst_cnt_q <= burst_cnt_d;
      timer_q     <= timer_d;
    end
  end

`ifdef STATS_EN
  logic [15:0] stat_bytes_q, stat_bytes_d;
  logic [15:0] stat_bursts_q, stat_bursts_d;

  // Transfer counters, wrap naturally at 16 bits.
  always_comb begin
    stat_bytes_d  = stat_bytes_q;
    stat_bursts_d = stat_bursts_q;
    if (xfer) stat_bytes_d = stat_bytes_q + 16'd1;
    if (xfer && buf0_q.eop) stat_bursts_d = stat_bursts_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bytes_q  <= '0;
      stat_bursts_q <= '0;
    end else begin
      stat_bytes_q  <= stat_bytes_d;
      stat_bursts_q <= stat_bursts_d;
    end
  end

  assign stat_bytes  = stat_bytes_q;
  assign stat_bursts = stat_bursts_q;
`else
  assign stat_bytes  = 16'd0;
  assign stat_bursts = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (BURST_LEN=4, TIMEOUT=8) with a simple
// FIFO source model and an output capture log.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_threshold;
  logic [7:0]  fifo_data;
  logic        fifo_rd;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_sop;
  logic        m_eop;
  logic [15:0] stat_bytes;
  logic [15:0] stat_bursts;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO source model
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       thr_en = 1'b0;
  logic       flush  = 1'b0;
  logic       pop_pend = 1'b0;
  int         pop_cnt = 0;
  int         underflow = 0;

  // Output capture log
  logic [7:0] out_d [0:63];
  logic       out_s [0:63];
  logic       out_e [0:63];
  int         out_n = 0;

  assign fifo_empty     = (rd_ptr == wr_ptr);
  assign fifo_threshold = thr_en && (8'(wr_ptr - rd_ptr) >= 8'd4);
  assign fifo_data      = mem[rd_ptr];

  fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop),
    .stat_bytes(stat_bytes), .stat_bursts(stat_bursts)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    pop_pend = fifo_rd;
    if (fifo_rd) pop_cnt++;
    if (fifo_rd && fifo_empty) underflow++;
    if (m_valid && m_ready && !rst && out_n < 64) begin
      out_d[out_n] = m_data;
      out_s[out_n] = m_sop;
      out_e[out_n] = m_eop;
      out_n++;
    end
  end

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (pop_pend && !fifo_empty) rd_ptr <= rd_ptr + 8'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = first + 8'(i);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  task automatic wait_out(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (out_n >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (out_n >= target) ok = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; m_ready = 1'b0; thr_en = 1'b0;
    tick(); tick();
    n_cmp++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_cmp++; if ({m_data, m_sop, m_eop} !== 10'd0) begin n_err++; $display("FAIL reset_out: got %h/%b/%b want 00/0/0", m_data, m_sop, m_eop); end
    n_cmp++; if ({stat_bytes, stat_bursts} !== 32'd0) begin n_err++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_bytes, stat_bursts); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_threshold_drain;
    int n0, p0; bit ok;
    logic [7:0] ed; logic es, ee;
    n0 = out_n; p0 = pop_cnt;
    m_ready = 1'b1;
    push_bytes(8'h01, 8);
    thr_en = 1'b1;
    wait_out(n0 + 8, 80, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL drain_timeout: got %0d bytes want 8", out_n - n0); end
    for (int i = 0; i < 8; i++) begin
      ed = 8'(i + 1); es = (i % 4 == 0); ee = (i % 4 == 3);
      n_cmp++;
      if ({out_d[n0+i], out_s[n0+i], out_e[n0+i]} !== {ed, es, ee}) begin
        n_err++;
        $display("FAIL drain_byte%0d: got %h sop%b eop%b want %h sop%b eop%b",
                 i, out_d[n0+i], out_s[n0+i], out_e[n0+i], ed, es, ee);
      end
    end
    repeat (6) tick();
    n_cmp++; if (pop_cnt - p0 != 8) begin n_err++; $display("FAIL drain_pops: got %0d want 8", pop_cnt - p0); end
    n_cmp++; if (out_n - n0 != 8) begin n_err++; $display("FAIL drain_count: got %0d want 8", out_n - n0); end
    n_cmp++; if (underflow != 0) begin n_err++; $display("FAIL drain_underflow: got %0d want 0", underflow); end
`ifdef STATS_EN
    n_cmp++; if (stat_bytes !== 16'd8) begin n_err++; $display("FAIL stat_bytes: got %0d want 8", stat_bytes); end
    n_cmp++; if (stat_bursts !== 16'd2) begin n_err++; $display("FAIL stat_bursts: got %0d want 2", stat_bursts); end
`else
    n_cmp++; if (stat_bytes !== 16'd0) begin n_err++; $display("FAIL stat_bytes: got %0d want 0", stat_bytes); end
    n_cmp++; if (stat_bursts !== 16'd0) begin n_err++; $display("FAIL stat_bursts: got %0d want 0", stat_bursts); end
`endif
    thr_en = 1'b0;
  endtask

  task automatic test_timeout;
    int n0, p0; bit ok;
    logic [7:0] ed; logic es, ee;
    repeat (4) tick();
    n0 = out_n; p0 = pop_cnt;
    push_bytes(8'hA1, 3);
    repeat (7) tick();
    n_cmp++; if (pop_cnt - p0 != 0) begin n_err++; $display("FAIL timeout_early_pop: got %0d pops want 0", pop_cnt - p0); end
    wait_out(n0 + 3, 40, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL timeout_wait: got %0d bytes want 3", out_n - n0); end
    for (int i = 0; i < 3; i++) begin
      ed = 8'hA1 + 8'(i); es = (i == 0); ee = (i == 2);
      n_cmp++;
      if ({out_d[n0+i], out_s[n0+i], out_e[n0+i]} !== {ed, es, ee}) begin
        n_err++;
        $display("FAIL timeout_byte%0d: got %h sop%b eop%b want %h sop%b eop%b",
                 i, out_d[n0+i], out_s[n0+i], out_e[n0+i], ed, es, ee);
      end
    end
    repeat (4) tick();
    n_cmp++; if (pop_cnt - p0 != 3) begin n_err++; $display("FAIL timeout_pops: got %0d want 3", pop_cnt - p0); end
  endtask

  task automatic test_backpressure;
    int n0, p0, bad; bit ok;
    logic [7:0] ed; logic es, ee;
    repeat (4) tick();
    m_ready = 1'b0;
    n0 = out_n; p0 = pop_cnt; bad = 0;
    push_bytes(8'h01, 8);
    thr_en = 1'b1;
    repeat (4) tick();
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if ({m_valid, m_data, m_sop} !== {1'b1, 8'h01, 1'b1}) begin
        n_err++;
        $display("FAIL bp_hold_c%0d: got v%b %h sop%b want v1 01 sop1", c, m_valid, m_data, m_sop);
      end
    end
    n_cmp++; if (pop_cnt - p0 != 3) begin n_err++; $display("FAIL bp_pops: got %0d want 3", pop_cnt - p0); end
    m_ready = 1'b1;
    wait_out(n0 + 8, 80, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_wait: got %0d bytes want 8", out_n - n0); end
    for (int i = 0; i < 8; i++) begin
      ed = 8'(i + 1); es = (i % 4 == 0); ee = (i % 4 == 3);
      n_cmp++;
      if ({out_d[n0+i], out_s[n0+i], out_e[n0+i]} !== {ed, es, ee}) begin
        n_err++;
        $display("FAIL bp_byte%0d: got %h sop%b eop%b want %h sop%b eop%b",
                 i, out_d[n0+i], out_s[n0+i], out_e[n0+i], ed, es, ee);
      end
    end
    thr_en = 1'b0;
    repeat (6) tick();
    n_cmp++; if (pop_cnt - p0 != 8) begin n_err++; $display("FAIL bp_total_pops: got %0d want 8", pop_cnt - p0); end
  endtask

  task automatic test_single;
    int n0, p0; bit ok;
    repeat (4) tick();
    n0 = out_n; p0 = pop_cnt;
    push_bytes(8'h5A, 1);
    wait_out(n0 + 1, 40, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_wait: got %0d bytes want 1", out_n - n0); end
    n_cmp++;
    if ({out_d[n0], out_s[n0], out_e[n0]} !== {8'h5A, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL single_byte: got %h sop%b eop%b want 5a sop1 eop1", out_d[n0], out_s[n0], out_e[n0]);
    end
    repeat (12) tick();
    n_cmp++; if (pop_cnt - p0 != 1) begin n_err++; $display("FAIL single_pops: got %0d want 1", pop_cnt - p0); end
    n_cmp++; if (out_n - n0 != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", out_n - n0); end
    n_cmp++; if (underflow != 0) begin n_err++; $display("FAIL single_underflow: got %0d want 0", underflow); end
  endtask

  task automatic test_reset_mid_burst;
    int n0, p0, c; bit ok;
    logic [7:0] ed; logic es, ee;
    repeat (4) tick();
    m_ready = 1'b1;
    p0 = pop_cnt;
    push_bytes(8'h01, 8);
    thr_en = 1'b1;
    c = 0;
    while ((pop_cnt - p0 < 2) && (c < 30)) begin
      tick();
      c++;
    end
    n_cmp++; if (pop_cnt - p0 < 2) begin n_err++; $display("FAIL rstmid_pops: got %0d want 2", pop_cnt - p0); end
    rst = 1'b1; thr_en = 1'b0;
    tick();
    n_cmp++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL rstmid_fifo_rd: got %b want 0", fifo_rd); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_m_valid: got %b want 0", m_valid); end
    tick();
    rst = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n0 = out_n;
    push_bytes(8'h11, 4);
    thr_en = 1'b1;
    wait_out(n0 + 4, 40, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_wait: got %0d bytes want 4", out_n - n0); end
    for (int i = 0; i < 4; i++) begin
      ed = 8'h11 + 8'(i); es = (i == 0); ee = (i == 3);
      n_cmp++;
      if ({out_d[n0+i], out_s[n0+i], out_e[n0+i]} !== {ed, es, ee}) begin
        n_err++;
        $display("FAIL rstmid_byte%0d: got %h sop%b eop%b want %h sop%b eop%b",
                 i, out_d[n0+i], out_s[n0+i], out_e[n0+i], ed, es, ee);
      end
    end
    thr_en = 1'b0;
    repeat (10) tick();
    n_cmp++; if (out_n - n0 != 4) begin n_err++; $display("FAIL rstmid_count: got %0d want 4", out_n - n0); end
  endtask

  initial begin
    rst = 1'b1;
    m_ready = 1'b0;
    test_reset();
    test_threshold_drain();
    test_timeout();
    test_backpressure();
    test_single();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
